// File: rtl/maze_pkg.sv
// Shared definitions for the maze path generator: grid size defaults,
// LFSR constants and the controller state encoding.
package maze_pkg;

  localparam int MAX_W_DEF = 3;
  localparam int MAX_H_DEF = 3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WALK  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit right-shifting Galois LFSR; free-running, with a seed load that
// takes priority over the shift. A zero seed is replaced by the default.
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= (seed == 16'h0000) ? LFSR_SEED : seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/maze_path_gen.sv
// Generates a random monotone (right/down) path from cell (0,0) to (W-1,H-1)
// and exposes it as a column-major cell bitmap.
module maze_path_gen
  import maze_pkg::*;
#(
  parameter int MAX_W = MAX_W_DEF,
  parameter int MAX_H = MAX_H_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step_en,
  input  logic                     seed_load,
  input  logic [15:0]              seed,
  input  logic [2:0]               maze_width,
  input  logic [2:0]               maze_height,
  output logic                     busy,
  output logic                     done,
  output logic                     path_valid,
  output logic [MAX_W*MAX_H-1:0]   path_data
);

  localparam int NCELLS = MAX_W * MAX_H;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  dim_w;
  logic [2:0]  dim_h;
  logic [2:0]  col;
  logic [2:0]  row;
  logic [2:0]  col_nxt;
  logic [2:0]  row_nxt;
  logic        step;
  logic [5:0]  cell_idx;
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  function automatic logic [2:0] clamp_dim(input logic [2:0] req, input logic [2:0] lim);
    logic [2:0] res;
    if (req == 3'd0) begin
      res = 3'd1;
    end else if (req > lim) begin
      res = lim;
    end else begin
      res = req;
    end
    return res;
  endfunction

  maze_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed),
    .q     (lfsr_q)
  );

  // Only bit 0 steers the walk; the rest of the register is internal state.
  assign unused_lfsr = ^lfsr_q[15:1];

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = ((dim_w == 3'd1) && (dim_h == 3'd1)) ? ST_DONE : ST_WALK;
      end
      ST_WALK: begin
        if (step_en) begin
          step = 1'b1;
          // Edges of the grid force the direction; interior cells use the LFSR.
          if (col == dim_w - 3'd1) begin
            row_nxt = row + 3'd1;
          end else if (row == dim_h - 3'd1) begin
            col_nxt = col + 3'd1;
          end else if (lfsr_q[0]) begin
            col_nxt = col + 3'd1;
          end else begin
            row_nxt = row + 3'd1;
          end
          if ((col_nxt == dim_w - 3'd1) && (row_nxt == dim_h - 3'd1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cell_idx = 6'(col_nxt) * 6'(MAX_H) + 6'(row_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dim_w      <= 3'd1;
      dim_h      <= 3'd1;
      col        <= 3'd0;
      row        <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      path_valid <= 1'b0;
      path_data  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_CLEAR) || (state_nxt == ST_WALK);
      done  <= (state_nxt == ST_DONE);
      // Accepted start: latch dims and present a cleared bitmap during CLEAR.
      if ((state == ST_IDLE) && start) begin
        dim_w      <= clamp_dim(maze_width, 3'(MAX_W));
        dim_h      <= clamp_dim(maze_height, 3'(MAX_H));
        col        <= 3'd0;
        row        <= 3'd0;
        path_data  <= NCELLS'(1);
        path_valid <= 1'b0;
      end
      if (step) begin
        col       <= col_nxt;
        row       <= row_nxt;
        path_data <= path_data | (NCELLS'(1) << cell_idx);
      end
      if (state_nxt == ST_DONE) path_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maze_path_gen.sv
// Directed bench for maze_path_gen (3x3 default) with hand-derived paths.
module tb_maze_path_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        step_en;
  logic        seed_load;
  logic [15:0] seed;
  logic [2:0]  maze_width;
  logic [2:0]  maze_height;
  logic        busy;
  logic        done;
  logic        path_valid;
  logic [8:0]  path_data;

  int checks = 0;
  int errors = 0;

  int          g_busy;
  int          g_done;
  int          g_idx;
  logic [8:0]  g_snap;
  logic        g_pv2;
  logic [8:0]  g_final;
  logic        g_pvf;

  always #5 clk = ~clk;

  maze_path_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .step_en     (step_en),
    .seed_load   (seed_load),
    .seed        (seed),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .busy        (busy),
    .done        (done),
    .path_valid  (path_valid),
    .path_data   (path_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a walk with step_en held high; index 0 is the state after the start edge.
  task automatic go(input logic [2:0] w, input logic [2:0] h,
                    input logic load_clr, input logic [15:0] sd);
    maze_width  = w;
    maze_height = h;
    start       = 1'b1;
    step_en     = 1'b1;
    seed_load   = 1'b0;
    cyc();
    start     = 1'b0;
    seed_load = load_clr;
    seed      = sd;
    g_busy = 0;
    g_done = 0;
    g_idx  = -1;
    g_snap = '0;
    g_pv2  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (busy) g_busy++;
      if (done) begin
        g_done++;
        if (g_idx < 0) g_idx = i;
      end
      if (i == 2) begin
        g_snap = path_data;
        g_pv2  = path_valid;
      end
      cyc();
      seed_load = 1'b0;
    end
    g_final = path_data;
    g_pvf   = path_valid;
  endtask

  initial begin
    int         done_j;
    int         done_seen;
    logic [8:0] snap_a;
    logic [8:0] snap_b;
    logic [8:0] path_toggled;

    reset       = 1'b1;
    start       = 1'b0;
    step_en     = 1'b0;
    seed_load   = 1'b0;
    seed        = 16'h0000;
    maze_width  = 3'd3;
    maze_height = 3'd3;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(path_valid), 32'd0);
    chk("rst_path", 32'(path_data), 32'd0);
    reset = 1'b0;

    // 3x3, seed 0001 loaded the cycle before start: LFSR bit 0 stays low -> down,down,right,right.
    seed_load = 1'b1;
    seed      = 16'h0001;
    cyc();
    seed_load = 1'b0;
    go(3'd3, 3'd3, 1'b0, 16'h0000);
    chk("w33_busy_cycles", 32'(g_busy), 32'd5);
    chk("w33_done_pulses", 32'(g_done), 32'd1);
    chk("w33_done_latency", 32'(g_idx), 32'd5);
    chk("w33_live_path", 32'(g_snap), 32'h003);
    chk("w33_valid_midwalk", 32'(g_pv2), 32'd0);
    chk("w33_path", 32'(g_final), 32'h127);
    chk("w33_popcount", 32'($countones(g_final)), 32'd5);
    chk("w33_valid", 32'(g_pvf), 32'd1);

    // Seed 0001 loaded during CLEAR: first step sees bit 0 high -> right, then down,down,right.
    go(3'd3, 3'd3, 1'b1, 16'h0001);
    chk("w33b_path", 32'(g_final), 32'h139);
    chk("w33b_live_path", 32'(g_snap), 32'h009);
    chk("w33b_done_pulses", 32'(g_done), 32'd1);

    // 1x1 goes straight from CLEAR to DONE.
    go(3'd1, 3'd1, 1'b0, 16'h0000);
    chk("w11_path", 32'(g_final), 32'h001);
    chk("w11_valid", 32'(g_pvf), 32'd1);
    chk("w11_busy_cycles", 32'(g_busy), 32'd1);
    chk("w11_done_latency", 32'(g_idx), 32'd1);

    // Clamping: 0x7 -> 1x3 and 7x0 -> 3x1.
    go(3'd0, 3'd7, 1'b0, 16'h0000);
    chk("clamp13_path", 32'(g_final), 32'h007);
    chk("clamp13_done_latency", 32'(g_idx), 32'd3);
    go(3'd7, 3'd0, 1'b0, 16'h0000);
    chk("clamp31_path", 32'(g_final), 32'h049);
    chk("clamp31_done_latency", 32'(g_idx), 32'd3);

    // step_en 1-in-4, seed 0001 reloaded just before each step; stray start mid-walk.
    maze_width  = 3'd3;
    maze_height = 3'd3;
    start       = 1'b1;
    step_en     = 1'b0;
    cyc();
    start     = 1'b0;
    done_j    = -1;
    done_seen = 0;
    snap_a    = '0;
    snap_b    = '0;
    for (int j = 1; j <= 22; j++) begin
      step_en   = ((j % 4) == 3);
      seed_load = ((j % 4) == 2);
      seed      = 16'h0001;
      start     = (j == 5);
      maze_width  = (j == 5) ? 3'd1 : 3'd3;
      maze_height = (j == 5) ? 3'd1 : 3'd3;
      cyc();
      if (j == 4) snap_a = path_data;
      if (j == 5) chk("slow_busy_stray_start", 32'(busy), 32'd1);
      if (j == 6) snap_b = path_data;
      if (done) begin
        done_seen++;
        if (done_j < 0) done_j = j;
      end
    end
    start     = 1'b0;
    step_en   = 1'b0;
    seed_load = 1'b0;
    path_toggled = path_data;
    chk("slow_after_step1", 32'(snap_a), 32'h009);
    chk("slow_hold", 32'(snap_b), 32'h009);
    chk("slow_done_edge", 32'(done_j), 32'd15);
    chk("slow_done_pulses", 32'(done_seen), 32'd1);
    chk("slow_path", 32'(path_toggled), 32'h1C9);

    // Reference with step_en held high and the same LFSR state at every step.
    start   = 1'b1;
    step_en = 1'b1;
    cyc();
    start  = 1'b0;
    done_j = -1;
    for (int j = 1; j <= 10; j++) begin
      seed_load = 1'b1;
      seed      = 16'h0001;
      cyc();
      if (done && (done_j < 0)) done_j = j;
    end
    seed_load = 1'b0;
    chk("fast_done_edge", 32'(done_j), 32'd5);
    chk("fast_path", 32'(path_data), 32'h1C9);
    chk("fast_vs_slow", 32'(path_data), 32'(path_toggled));

    // Reset asserted right after the second walk step.
    seed_load = 1'b1;
    seed      = 16'h0001;
    cyc();
    seed_load   = 1'b0;
    maze_width  = 3'd3;
    maze_height = 3'd3;
    start       = 1'b1;
    step_en     = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("abort_pre_path", 32'(path_data), 32'h007);
    reset = 1'b1;
    #1;
    chk("abort_async_outputs", {20'd0, busy, done, path_valid, path_data}, 32'd0);
    cyc();
    chk("abort_next_cycle", {20'd0, busy, done, path_valid, path_data}, 32'd0);
    reset     = 1'b0;
    done_seen = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    seed_load = 1'b1;
    seed      = 16'h0001;
    cyc();
    seed_load = 1'b0;
    go(3'd3, 3'd3, 1'b0, 16'h0000);
    chk("after_abort_path", 32'(g_final), 32'h127);
    chk("after_abort_done", 32'(g_done), 32'd1);

    // Same seed (zero -> ACE1) at the same offset twice: identical paths.
    go(3'd3, 3'd3, 1'b1, 16'h0000);
    snap_a = g_final;
    go(3'd3, 3'd3, 1'b1, 16'h0000);
    chk("repeat_run1", 32'(snap_a), 32'h139);
    chk("repeat_run2", 32'(g_final), 32'h139);
    chk("repeat_equal", 32'(g_final), 32'(snap_a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_path_gen.md
MAZE_PATH_GEN -- requirements
Module: maze_path_gen

Interface
REQ-001 Parameter MAX_W, default 3, maximum grid columns (1..7).
REQ-002 Parameter MAX_H, default 3, maximum grid rows (1..7).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to generate a new path.
REQ-006 step_en  input  1  advance qualifier; walk moves only on cycles where high.
REQ-007 seed_load  input  1  load seed into LFSR this cycle.
REQ-008 seed  input  16  LFSR seed value.
REQ-009 maze_width  input  3  requested columns, sampled on accepted start.
REQ-010 maze_height  input  3  requested rows, sampled on accepted start.
REQ-011 busy  output  1  high in CLEAR and WALK states.
REQ-012 done  output  1  one-cycle pulse, high only in DONE state.
REQ-013 path_valid  output  1  bitmap holds a complete path.
REQ-014 path_data  output  MAX_W*MAX_H  cell bitmap; cell (col c, row r) at bit c*MAX_H + r; 1 = path cell.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR, WALK, DONE, with all outputs registered.
REQ-016 IDLE: start=1 SHALL latch clamped dims (0 -> 1, >MAX -> MAX) into W/H and enter CLEAR; start outside IDLE SHALL be ignored.
REQ-017 CLEAR (one cycle): bitmap SHALL become only bit 0 set, cursor (0,0), path_valid cleared; next state WALK, or DONE if W=1 and H=1.
REQ-018 WALK with step_en=1: if cursor col = W-1 move down; else if row = H-1 move right; else lfsr[0]=1 moves right, 0 moves down; new cell bit SHALL be set.
REQ-019 WALK with step_en=0: cursor, bitmap and state SHALL hold.
REQ-020 When a step lands on (W-1,H-1) the next state SHALL be DONE; a walk SHALL take exactly W+H-2 steps and set exactly W+H-1 bits.
REQ-021 DONE (one cycle): done=1, path_valid SHALL be set, next state IDLE.
REQ-022 path_data SHALL show the bitmap live during WALK; bits outside W x H SHALL stay 0.
REQ-023 LFSR: 16-bit Galois, taps 16'hB400, shifts every clock regardless of state.
REQ-024 seed_load=1 SHALL load seed (16'hACE1 if seed=0) and take priority over the shift that cycle; seed_load is allowed in any state.
REQ-025 Latency: start accepted at edge k -> busy=1 after k; WALK after k+1; with step_en held high done=1 after edge k+1+W+H-2.

Reset
REQ-026 Reset SHALL force IDLE, busy=0, done=0, path_valid=0, path_data=0, W=H=1, cursor (0,0), LFSR=16'hACE1.
REQ-027 Reset asserted mid-walk SHALL abort immediately with no done pulse.

Structure
REQ-028 Shared package maze_pkg SHALL hold MAX_W/MAX_H defaults, LFSR taps, default seed, state encoding.
REQ-029 LFSR SHALL be sub-module maze_lfsr (ports clk, reset, load, seed, q[15:0]).
REQ-030 Output bit ordering SHALL match the renderer's column-major path input (9 bits for 3x3).

Verification
REQ-031 Reset, seed_load seed=16'h0001, start W=3 H=3, step_en=1 -> busy high 5 cycles, done pulse once, popcount(path_data)=5, bits 0 and 8 set, path monotone right/down.
REQ-032 start W=1 H=1 -> CLEAR then DONE; path_data=9'b000000001, path_valid=1.
REQ-033 start W=0 H=7 with MAX 3x3 -> clamped 1x3; path_data=9'b000000111 after 2 steps.
REQ-034 step_en toggled 1-in-4 on 3x3 -> same path as step_en=1 run with same LFSR state per step; done 4 steps after WALK entry; second start during WALK ignored.
REQ-035 Reset asserted at 2nd WALK step -> all outputs 0 next cycle, no done; fresh start completes normally.
REQ-036 Same seed loaded at same cycle offset before two starts -> identical path_data both runs.
